// File: rtl/duty_cycle_pkg.sv
// duty_cycle_pkg: shared state encoding, default width and config record for the duty-cycle generator.
package duty_cycle_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] high;
      logic [DEF_WIDTH-1:0] low;
      logic [DEF_WIDTH-1:0] phase;
   } cfg_t;

   // A period is impossible when either half is zero cycles long.
   function automatic logic cfg_zero(input logic [31:0] h, input logic [31:0] l);
      return h == 32'd0 || l == 32'd0;
   endfunction

endpackage

// File: rtl/dc_down_counter.sv
// dc_down_counter: loadable down-counter that saturates at zero and flags it.
module dc_down_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_dec,
   output logic             o_zero
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_cnt <= '0;
      else if (i_load) r_cnt <= i_val;
      else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - ONE;
   end

   assign o_zero = r_cnt == '0;

endmodule

// File: rtl/duty_cycle_gen.sv
// duty_cycle_gen: programmable high/low/phase clock generator with glitch-free reload at period boundaries.
module duty_cycle_gen
   import duty_cycle_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             LOCKED,
   input  logic             load,
   input  logic [WIDTH-1:0] high_time,
   input  logic [WIDTH-1:0] low_time,
   input  logic [WIDTH-1:0] phase_delay,
   output logic             clk_out,
   output logic             period_done,
   output logic             running,
   output logic             cfg_err
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef struct packed {
      logic [WIDTH-1:0] high;
      logic [WIDTH-1:0] low;
      logic [WIDTH-1:0] phase;
   } wcfg_t;

   state_t           r_state;
   wcfg_t            r_act, r_pend, w_in, w_next;
   logic             r_pend_valid, r_clk_out, r_running, r_cfg_err;
   logic             w_zero, w_start, w_bad_act, w_bad_next, w_boundary;
   logic             w_cnt_load, w_cnt_dec;
   logic [WIDTH-1:0] w_cnt_val;

   assign w_in       = '{high: high_time, low: low_time, phase: phase_delay};
   assign w_next     = r_pend_valid ? r_pend : r_act;
   assign w_bad_act  = cfg_zero(32'(r_act.high), 32'(r_act.low));
   assign w_bad_next = cfg_zero(32'(w_next.high), 32'(w_next.low));
   // A load in IDLE wins over starting so the start always sees the freshly written config.
   assign w_start    = r_state == ST_IDLE && !load && LOCKED && !r_cfg_err;
   assign w_boundary = r_state == ST_LOW && w_zero && LOCKED;
   assign w_cnt_dec  = LOCKED && r_state != ST_IDLE && !w_zero;

   always_comb begin
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;
      if (!LOCKED) w_cnt_load = r_state != ST_IDLE;
      else if (r_state == ST_IDLE) begin
         w_cnt_load = w_start && !w_bad_act;
         w_cnt_val  = (r_act.phase == '0 ? r_act.high : r_act.phase) - ONE;
      end else if (w_zero) begin
         w_cnt_load = 1'b1;
         w_cnt_val  = r_state == ST_DELAY ? r_act.high - ONE :
                      r_state == ST_HIGH  ? r_act.low - ONE  :
                      w_bad_next          ? '0               : w_next.high - ONE;
      end
   end

   dc_down_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_cnt_load),
      .i_val  (w_cnt_val),
      .i_dec  (w_cnt_dec),
      .o_zero (w_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_act        <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
         r_clk_out    <= 1'b0;
         r_running    <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         if (load && r_state != ST_IDLE) begin
            r_pend       <= w_in;
            r_pend_valid <= 1'b1;
         end else if (w_boundary) r_pend_valid <= 1'b0;
         if (r_state != ST_IDLE && !LOCKED) begin
            r_state   <= ST_IDLE;
            r_clk_out <= 1'b0;
            r_running <= 1'b0;
         end else if (r_state == ST_IDLE) begin
            if (load) begin
               r_act     <= w_in;
               r_cfg_err <= 1'b0;
            end else if (w_start && w_bad_act) r_cfg_err <= 1'b1;
            else if (w_start) begin
               r_state   <= r_act.phase == '0 ? ST_HIGH : ST_DELAY;
               r_clk_out <= r_act.phase == '0;
               r_running <= 1'b1;
            end
         end else if (w_zero) begin
            if (r_state == ST_DELAY) begin
               r_state   <= ST_HIGH;
               r_clk_out <= 1'b1;
            end else if (r_state == ST_HIGH) begin
               r_state   <= ST_LOW;
               r_clk_out <= 1'b0;
            end else begin
               r_act <= w_next;
               if (w_bad_next) begin
                  r_state   <= ST_IDLE;
                  r_running <= 1'b0;
                  r_cfg_err <= 1'b1;
               end else begin
                  r_state   <= ST_HIGH;
                  r_clk_out <= 1'b1;
               end
            end
         end
      end
   end

   assign clk_out     = r_clk_out;
   assign running     = r_running;
   assign cfg_err     = r_cfg_err;
   assign period_done = r_state == ST_LOW && w_zero;

endmodule

// File: tb/tb_duty_cycle_gen.sv
// tb_duty_cycle_gen: directed stimulus, per-cycle check against a position-in-period model plus literal pins.
module tb_duty_cycle_gen;

   logic       clk, reset, LOCKED, load;
   logic [7:0] high_time, low_time, phase_delay;
   logic       clk_out, period_done, running, cfg_err;

   int tests = 0;
   int fails = 0;

   duty_cycle_gen #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .LOCKED      (LOCKED),
      .load        (load),
      .high_time   (high_time),
      .low_time    (low_time),
      .phase_delay (phase_delay),
      .clk_out     (clk_out),
      .period_done (period_done),
      .running     (running),
      .cfg_err     (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: position within the current period; negative while the phase delay elapses.
   int m_h = 0, m_l = 0, m_p = 0, m_ph = 0, m_pl = 0, m_pp = 0, m_pos = 0;
   int oh, ol, op;
   bit m_run = 0, m_err = 0, m_pv = 0, opv;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_h = 0; m_l = 0; m_p = 0; m_ph = 0; m_pl = 0; m_pp = 0;
         m_pos = 0; m_run = 0; m_err = 0; m_pv = 0;
      end else if (m_run) begin
         opv = m_pv; oh = m_ph; ol = m_pl; op = m_pp;
         if (load) begin
            m_ph = int'(high_time); m_pl = int'(low_time); m_pp = int'(phase_delay); m_pv = 1;
         end
         if (!LOCKED) m_run = 0;
         else if (m_pos == m_h + m_l - 1) begin
            if (opv) begin
               m_h = oh; m_l = ol; m_p = op;
               if (!load) m_pv = 0;
            end
            if (m_h == 0 || m_l == 0) begin
               m_run = 0; m_err = 1;
            end else m_pos = 0;
         end else m_pos++;
      end else if (load) begin
         m_h = int'(high_time); m_l = int'(low_time); m_p = int'(phase_delay); m_err = 0;
      end else if (LOCKED && !m_err) begin
         if (m_h == 0 || m_l == 0) m_err = 1;
         else begin
            m_run = 1; m_pos = -m_p;
         end
      end
   end

   logic [3:0] exp_v, got_v;
   always @(negedge clk) begin
      exp_v = {m_run && m_pos >= 0 && m_pos < m_h, m_run && m_pos == m_h + m_l - 1, m_run, m_err};
      got_v = {clk_out, period_done, running, cfg_err};
      tests++;
      if (got_v !== exp_v) begin
         fails++;
         $display("FAIL model t=%0t {clk_out,period_done,running,cfg_err} got %b want %b", $time, got_v, exp_v);
      end
   end

   task automatic check(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic do_load(input int h, input int l, input int p);
      load = 1'b1; high_time = 8'(h); low_time = 8'(l); phase_delay = 8'(p);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic count(input int n, output int hi, output int pd);
      hi = 0; pd = 0;
      repeat (n) begin
         @(negedge clk);
         hi += int'(clk_out);
         pd += int'(period_done);
      end
   endtask

   int hi, pd;

   initial begin
      reset = 1'b1; LOCKED = 1'b0; load = 1'b0;
      high_time = '0; low_time = '0; phase_delay = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_outputs", int'({clk_out, period_done, running, cfg_err}), 0);
      // Nominal 5/5, phase 0: high right after the start edge.
      do_load(5, 5, 0);
      LOCKED = 1'b1;
      @(negedge clk);
      check("nominal_first_high", int'(clk_out), 1);
      count(19, hi, pd);
      check("nominal_highs", hi, 9);
      check("nominal_period_done", pd, 2);
      // Reload 2/8 in the first HIGH cycle: current period completes 5/5 first.
      @(negedge clk);
      do_load(2, 8, 0);
      count(8, hi, pd);
      check("reload_old_rest_highs", hi, 3);
      check("reload_old_rest_pd", pd, 1);
      count(10, hi, pd);
      check("reload_new_highs", hi, 2);
      check("reload_new_pd", pd, 1);
      // LOCKED drop in the last LOW cycle, then 3/7 with phase 4.
      LOCKED = 1'b0;
      @(negedge clk);
      check("locked_drop_running", int'(running), 0);
      do_load(3, 7, 4);
      LOCKED = 1'b1;
      count(4, hi, pd);
      check("phase_delay_low", hi, 0);
      count(10, hi, pd);
      check("skew_highs", hi, 3);
      check("skew_pd", pd, 1);
      // Pending 6/2 loaded mid-LOW, LOCKED dropped mid-LOW, pending survives the restart.
      count(5, hi, pd);
      do_load(6, 2, 0);
      LOCKED = 1'b0;
      @(negedge clk);
      check("drop_mid_low_running", int'(running), 0);
      check("drop_mid_low_clk", int'(clk_out), 0);
      LOCKED = 1'b1;
      count(4, hi, pd);
      check("restart_phase_low", hi, 0);
      count(10, hi, pd);
      check("restart_old_highs", hi, 3);
      count(8, hi, pd);
      check("pending_applied_highs", hi, 6);
      check("pending_applied_pd", pd, 1);
      // Load at the boundary edge lands in pending; zero high takes effect one period later.
      do_load(0, 3, 0);
      count(7, hi, pd);
      check("boundary_load_deferred_highs", hi, 5);
      @(negedge clk);
      check("pending_zero_cfg_err", int'(cfg_err), 1);
      check("pending_zero_running", int'(running), 0);
      // Zero high loaded in IDLE: error on start attempt, cleared by a valid load.
      LOCKED = 1'b0;
      do_load(0, 4, 0);
      LOCKED = 1'b1;
      @(negedge clk);
      check("idle_zero_cfg_err", int'(cfg_err), 1);
      count(3, hi, pd);
      check("idle_zero_clk_stays_low", hi, 0);
      do_load(4, 4, 0);
      check("cfg_err_cleared", int'(cfg_err), 0);
      @(negedge clk);
      check("restart_after_err_high", int'(clk_out), 1);
      // Asynchronous reset mid-HIGH.
      #2 reset = 1'b1;
      #1 check("async_reset_mid_high", int'({clk_out, period_done, running, cfg_err}), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/duty_cycle_gen.md
# duty_cycle_gen

Synchronous clock-output generator that produces a divided clock with programmable high time, low time and initial phase delay, all counted in input-clock cycles. It is the producing end of the duty-cycle path: it models a PLL/MMCM output counter, and its `clk_out` is the signal `duty_cycle_check` monitors. Output is released only while `LOCKED` is high. Configuration changes take effect glitch-free at period boundaries.

## Interface
- `WIDTH`, 8: width of all count fields.
- `clk` input 1: reference clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `LOCKED` input 1: enable; generator runs only while high.
- `load` input 1: single-cycle strobe that captures `high_time`, `low_time` and `phase_delay`.
- `high_time` input WIDTH: cycles `clk_out` is high per period, 1..2^WIDTH-1.
- `low_time` input WIDTH: cycles `clk_out` is low per period, 1..2^WIDTH-1.
- `phase_delay` input WIDTH: cycles from start until the first rising edge of `clk_out`.
- `clk_out` output 1: generated clock, registered.
- `period_done` output 1: one-cycle pulse in the last LOW cycle of each period.
- `running` output 1: high in DELAY, HIGH and LOW states.
- `cfg_err` output 1: sticky flag; the active configuration has a zero high or low time.

## Operation
- Registers:
  - Active config (`act_*`), used by the counters.
  - Pending config (`pend_*`) plus a `pend_valid` flag.
  - State, and a WIDTH-bit down-counter `cnt`.
- States:
  - IDLE: `clk_out` = 0, `running` = 0.
  - DELAY: `clk_out` = 0.
  - HIGH: `clk_out` = 1.
  - LOW: `clk_out` = 0.
- `load`:
  - In IDLE: writes the active config directly and clears `cfg_err`.
  - In any other state: writes the pending config and sets `pend_valid`. A second `load` overwrites the pending config.
- IDLE → start, taken when `LOCKED` = 1 and `cfg_err` = 0:
  - If `act_high` = 0 or `act_low` = 0: stay in IDLE and set `cfg_err`.
  - Else if `act_phase` = 0: go to HIGH with `cnt` = `act_high`-1.
  - Else: go to DELAY with `cnt` = `act_phase`-1.
- DELAY: while `cnt` ≠ 0, decrement. When `cnt` = 0, go to HIGH with `cnt` = `act_high`-1.
- HIGH: while `cnt` ≠ 0, decrement. When `cnt` = 0, go to LOW with `cnt` = `act_low`-1.
- LOW: while `cnt` ≠ 0, decrement. When `cnt` = 0, this is the boundary:
  - Assert `period_done` for this cycle.
  - If `pend_valid`: copy pending to active and clear `pend_valid`.
  - If the new high or low time is 0: go to IDLE and set `cfg_err`.
  - Else: go to HIGH with `cnt` = new `high_time`-1. Phase delay is not re-applied.
- `LOCKED` falling in any non-IDLE state: IDLE at the next edge, `clk_out` = 0, pending config retained. `LOCKED` has priority over all other transitions.
- `load` at the same edge as a boundary lands in the pending config and is applied at the following boundary.
- Leaving `cfg_err`: a `load` with valid values clears it; the start path then re-runs, including phase delay.
- Resulting waveform: period = `high_time` + `low_time` cycles; duty = `high_time` / (`high_time` + `low_time`).

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0, `pend_valid` 0, active config 0.
- Because active config resets to 0, a `load` is required before the first start.
- Start latency: `LOCKED` is sampled high at edge N in IDLE; `clk_out` rises after edge N+`act_phase`. With phase 0, `clk_out` rises after edge N.
- `clk_out`, `period_done`, `running` and `cfg_err` are all registered; none is combinational from inputs.
- Reset asserted mid-period: `clk_out` drops asynchronously; no partial period is completed.

## Structure
- Shared package `duty_cycle_pkg`:
  - State encoding: IDLE=0, DELAY=1, HIGH=2, LOW=3.
  - Default `WIDTH`.
  - Config record type {high, low, phase}.
- Sub-module `dc_down_counter` (WIDTH parameter):
  - Inputs: load, load value, decrement enable.
  - Output: `zero`.
  - Used once for `cnt`; the FSM wraps it.

## Test plan
- Reset: assert `reset` mid-HIGH → `clk_out`, `running`, `period_done` and `cfg_err` go to 0 immediately.
- Nominal 50 %: load high=5, low=5, phase=0, `LOCKED`=1 → `clk_out` period 10 cycles, 5 high. `duty_cycle_check` (desired 0.5, clk_period = 10 × clk period) keeps `fail` = 0 over 1000 ns.
- Phase and skew: load high=3, low=7, phase=4 → first rise 4 cycles after start, then 30 % duty. Checker at 0.5 → `fail` = 1; checker at 0.3 → `fail` = 0.
- Reload: running 5/5, load 2/8 mid-HIGH → current period finishes 5/5, `period_done` pulses, next period is 2/8 with no runt pulse.
- Error: load high=0, low=4 in IDLE, `LOCKED`=1 → `cfg_err` = 1, `clk_out` stays 0. Then load 4/4 → `cfg_err` clears and the generator starts.
- `LOCKED` drop: deassert `LOCKED` mid-LOW → IDLE next edge. Reassert → restart with phase delay from the start-latency rule.
